// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the block-transfer memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int   WORDS_PER_BLOCK = 4;
    localparam logic READ            = 1'b0;
    localparam logic WRITE           = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and main-memory signal bundle for mem_arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
);
    logic                              req0;
    logic                              req1;
    logic                              rw0;
    logic                              rw1;
    logic [ADDR_W-5:0]                 blk0;
    logic [ADDR_W-5:0]                 blk1;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] wdata0;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] wdata1;
    logic [1:0]                        grant;
    logic                              done0;
    logic                              done1;
    logic [WORDS_PER_BLOCK*WORD_W-1:0] rdata;
    logic                              mem_en;
    logic                              mem_rw;
    logic [ADDR_W-1:0]                 mem_address;
    logic [WORD_W-1:0]                 mem_writeData;
    logic [WORD_W-1:0]                 mem_readData;
    logic                              mem_ready;

    modport slave (
        input  req0, req1, rw0, rw1, blk0, blk1, wdata0, wdata1,
        input  mem_readData, mem_ready,
        output grant, done0, done1, rdata,
        output mem_en, mem_rw, mem_address, mem_writeData
    );

    modport master (
        output req0, req1, rw0, rw1, blk0, blk1, wdata0, wdata1,
        output mem_readData, mem_ready,
        input  grant, done0, done1, rdata,
        input  mem_en, mem_rw, mem_address, mem_writeData
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with one-hot grant
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);
    // last_q holds the index of the requester granted most recently
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates two block requesters onto a single-word main-memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int BLK_W   = ADDR_W - 4;
    localparam int BLOCK_W = WORDS_PER_BLOCK * WORD_W;

    arb_state_e          state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          cnt_nxt;
    logic                rw_q, rw_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BLOCK_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0]  rbuf_q, rbuf_d;
    logic [BLOCK_W-1:0]  rdata_q, rdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wd_q, mem_wd_d;

    logic [1:0]          arb_gnt;
    logic                arb_update;
    logic                sel_rw;
    logic [BLK_W-1:0]    sel_blk;
    logic [BLOCK_W-1:0]  sel_wdata;

    rr_arbiter2 u_arb (
        .clk_i    (clock),
        .rst_i    (reset),
        .req_i    ({bus.req1, bus.req0}),
        .update_i (arb_update),
        .gnt_o    (arb_gnt)
    );

    assign sel_rw    = arb_gnt[1] ? bus.rw1    : bus.rw0;
    assign sel_blk   = arb_gnt[1] ? bus.blk1   : bus.blk0;
    assign sel_wdata = arb_gnt[1] ? bus.wdata1 : bus.wdata0;
    assign cnt_nxt   = cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        blk_d      = blk_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        mem_en_d   = mem_en_q;
        mem_rw_d   = mem_rw_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        arb_update = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    arb_update = 1'b1;
                    state_d    = ST_XFER;
                    grant_d    = arb_gnt;
                    cnt_d      = 2'd0;
                    rw_d       = sel_rw;
                    blk_d      = sel_blk;
                    wdata_d    = sel_wdata;
                    mem_en_d   = 1'b1;
                    mem_rw_d   = sel_rw;
                    mem_addr_d = {sel_blk, 2'd0, 2'b00};
                    mem_wd_d   = sel_wdata[WORD_W-1:0];
                end
            end
            ST_XFER: begin
                // Stalled accesses keep every registered output frozen
                if (bus.mem_ready) begin
                    if (rw_q == READ) begin
                        rbuf_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.mem_readData;
                    end
                    cnt_d = cnt_nxt;
                    if (cnt_q == 2'(WORDS_PER_BLOCK - 1)) begin
                        state_d  = ST_DONE;
                        mem_en_d = 1'b0;
                        done0_d  = grant_q[0];
                        done1_d  = grant_q[1];
                        rdata_d  = (rw_q == WRITE) ? wdata_q : rbuf_d;
                    end else begin
                        mem_addr_d = {blk_q, cnt_nxt, 2'b00};
                        mem_wd_d   = wdata_q[int'(cnt_nxt)*WORD_W +: WORD_W];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            cnt_q      <= 2'd0;
            rw_q       <= READ;
            blk_q      <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            blk_q      <= blk_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.done0         = done0_q;
    assign bus.done1         = done1_q;
    assign bus.rdata         = rdata_q;
    assign bus.mem_en        = mem_en_q;
    assign bus.mem_rw        = mem_rw_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_writeData = mem_wd_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, byte address width; block number is ADDR_W-4 bits.
REQ-002 Parameter: WORD_W, 32, memory word width; a block is 4 words (4*WORD_W bits).
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Ports: req0/req1  in  1  block-transfer request from requester 0 (I-cache) / 1 (D-cache).
REQ-007 Ports: rw0/rw1  in  1  transfer direction; 0 = read block from memory, 1 = write block to memory.
REQ-008 Ports: blk0/blk1  in  ADDR_W-4  block number (byte address bits [ADDR_W-1:4]).
REQ-009 Ports: wdata0/wdata1  in  4*WORD_W  block write data; word n is bits [32n+31:32n].
REQ-010 Port: grant  out  2  one-hot owner of the current transfer; 00 when idle.
REQ-011 Ports: done0/done1  out  1  one-cycle completion pulse to the owning requester.
REQ-012 Port: rdata  out  4*WORD_W  assembled read block, valid while doneN is high; word order as wdata.
REQ-013 Port: mem_en  out  1  memory access strobe.
REQ-014 Port: mem_rw  out  1  0 = read, 1 = write (main-memory encoding).
REQ-015 Port: mem_address  out  ADDR_W  word-aligned byte address {blk, word index, 2'b00}.
REQ-016 Port: mem_writeData  out  WORD_W  write word for the current access.
REQ-017 Ports: mem_readData  in  WORD_W; mem_ready  in  1 (access completes on the edge where mem_en and mem_ready are both high).

Function
REQ-018 FSM states IDLE, XFER, DONE; all outputs registered.
REQ-019 IDLE: if no req, stay; else pick a winner, latch its rw/blk/wdata, set grant, clear word counter, go XFER.
REQ-020 Arbitration round-robin: with both req high, the requester not granted last wins; with one req, it wins unconditionally.
REQ-021 Latched rw/blk/wdata are used for the entire burst; requester inputs may change after grant without effect.
REQ-022 XFER: mem_en=1, mem_rw=latched rw, mem_address={blk, cnt, 2'b00}, mem_writeData=wdata word cnt.
REQ-023 XFER: on an edge with mem_ready=1, read bursts capture mem_readData into buffer word cnt; cnt increments (2-bit).
REQ-024 XFER: mem_ready=0 holds cnt, address and data unchanged indefinitely (no timeout).
REQ-025 XFER: completion of word 3 goes DONE; cnt wraps to 0; mem_en drops to 0 in DONE.
REQ-026 DONE: exactly one cycle; done for the granted requester = 1, rdata = buffer (write bursts: rdata = latched wdata); go IDLE; grant -> 00.
REQ-027 Requester holds req high until its done pulse and deasserts it on the edge ending that pulse; req seen in DONE is ignored.
REQ-028 A new grant issues no earlier than the IDLE cycle after DONE (one idle bubble between bursts).
REQ-029 Minimum latency, mem_ready tied high: req sampled in IDLE at edge k, XFER edges k+1..k+4, done high in cycle after edge k+4.
REQ-030 Both done outputs never high together; grant never has both bits set.

Reset
REQ-031 Reset (including mid-burst) forces IDLE; grant=00, done0=done1=0, rdata=0, mem_en=0, mem_rw=0, mem_address=0, mem_writeData=0, cnt=0.
REQ-032 Reset sets last-granted to requester 1, so requester 0 wins the first simultaneous request; an aborted burst is dropped, never resumed.

Structure
REQ-033 Package mem_arb_pkg holds the state enum, WORDS_PER_BLOCK=4, and the rw encoding constants (READ=0, WRITE=1).
REQ-034 Sub-module rr_arbiter2 (2-input round-robin, one-hot grant, last-grant register with update enable) is instantiated once.

Verification
REQ-035 Single read: req0, rw0=0, blk0=6'h1A, ready tied 1, memory words 1..4 -> addresses 0x1A0,0x1A4,0x1A8,0x1AC; done0 one cycle later with rdata=128'h00000004_00000003_00000002_00000001.
REQ-036 Single write: req1, rw1=1, blk1=6'h05, wdata1 words A,B,C,D -> mem_rw=1 at 0x050..0x05C with A..D in order; done1 pulse; no done0.
REQ-037 Contention: req0 and req1 both raised in the same cycle after reset -> grant=01 first, then grant=10 after one idle cycle; a repeat contention grants 01 again.
REQ-038 Back-pressure: mem_ready low 3 cycles on word 2 -> mem_address holds at word-2 address, cnt holds, done delayed exactly 3 cycles.
REQ-039 Reset mid-burst: reset asserted after word 1 -> next cycle all outputs at reset values; re-requesting block restarts at word 0.
REQ-040 Input change after grant: blk0 changed during XFER -> addresses still use the latched block number.
